// File: rtl/net1_check_pkg.sv
// Shared types and constants for the net1 response checker.
//   state_t      : checker FSM states
//   NUM_COMBOS   : number of input combinations swept
//   IN_WIDTH     : width of the net1 input bus (abcd)
//   OUT_WIDTH    : width of the net1 output bus (xyz)
//   ERR_WIDTH    : width of the mismatch counter (holds 0..16)
//   expected_of  : pulls the expected xyz for one combination out of a packed table
package net1_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    localparam int NUM_COMBOS = 16;
    localparam int IN_WIDTH   = 4;
    localparam int OUT_WIDTH  = 3;
    localparam int ERR_WIDTH  = 5;

    function automatic logic [OUT_WIDTH-1:0] expected_of(
        input logic [NUM_COMBOS*OUT_WIDTH-1:0] tbl,
        input logic [IN_WIDTH-1:0]             idx
    );
        return tbl[OUT_WIDTH*idx +: OUT_WIDTH];
    endfunction

endpackage

// File: rtl/net1_sweep_checker_hold_timer.sv
// Hold timer: counts the cycles a combination has been applied.
//   clock  : system clock
//   reset  : asynchronous, active-high reset
//   clear  : force the count to zero
//   enable : advance the count; wraps to zero after reaching HOLD_CYCLES-1
//   last   : count == HOLD_CYCLES-1, i.e. this edge is the sample edge
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam logic [7:0] LAST_COUNT = 8'(HOLD_CYCLES - 1);

    logic [7:0] count_q, count_d;

    assign last = (count_q == LAST_COUNT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable) begin
            count_d = last ? 8'd0 : count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/net1_sweep_checker.sv
// Response checker for the net1 combinational block. A start pulse sweeps abcd
// through 0..15, holds each value HOLD_CYCLES cycles, samples xyz on the last
// cycle and scores it against EXPECTED.
//   clock      : system clock
//   reset      : asynchronous, active-high reset
//   start      : begin a sweep (ignored while one is running)
//   xyz        : net1 outputs {x,y,z}
//   abcd       : net1 inputs {a,b,c,d}, registered
//   busy       : sweep in progress
//   done       : sweep finished, held until next start or reset
//   pass       : valid with done; no mismatches seen
//   err_count  : number of mismatching combinations
//   first_fail : first mismatching combination
//   fail_valid : first_fail holds a recorded index
module net1_sweep_checker
    import net1_check_pkg::*;
#(
    parameter int unsigned                     HOLD_CYCLES = 10,
    parameter logic [NUM_COMBOS*OUT_WIDTH-1:0] EXPECTED    = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [OUT_WIDTH-1:0] xyz,
    output logic [IN_WIDTH-1:0]  abcd,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [IN_WIDTH-1:0]  first_fail,
    output logic                 fail_valid
);

    state_t               state_q, state_d;
    logic [IN_WIDTH-1:0]  idx_q, idx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [ERR_WIDTH-1:0] err_q, err_d;
    logic [IN_WIDTH-1:0]  ff_q, ff_d;
    logic                 fv_q, fv_d;

    logic                 hold_last;
    logic                 mismatch;
    logic [ERR_WIDTH-1:0] err_next;

    // Timer is held at zero outside DRIVE so every sweep starts from a fresh count.
    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_q != DRIVE),
        .enable (state_q == DRIVE),
        .last   (hold_last)
    );

    assign mismatch = (xyz != expected_of(EXPECTED, idx_q));
    // Count including the current sample, so the final pass verdict sees it.
    assign err_next = err_q + ERR_WIDTH'(mismatch);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ff_d    = ff_q;
        fv_d    = fv_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    ff_d    = '0;
                    fv_d    = 1'b0;
                end
            end
            DRIVE: begin
                if (hold_last) begin
                    if (mismatch) begin
                        err_d = err_next;
                        if (!fv_q) begin
                            ff_d = idx_q;
                            fv_d = 1'b1;
                        end
                    end
                    if (idx_q == IN_WIDTH'(NUM_COMBOS - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_next == '0);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
        end
    end

    assign abcd       = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign fail_valid = fv_q;

endmodule

// File: tb/tb_net1_sweep_checker.sv
// Bench for net1_sweep_checker. Three instances:
//   A: HOLD_CYCLES=10, table for xyz = abcd[2:0], fed by a faultable net1 model
//   B: HOLD_CYCLES=1,  same table and model
//   C: HOLD_CYCLES=1,  table all ones, xyz stuck at 0
module tb_net1_sweep_checker;

    // xyz = abcd[2:0]: octal digits 7..0 packed low-first, repeated for 8..15.
    localparam logic [47:0] EXP_GOOD = 48'hFAC688_FAC688;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    int   sel   = 0;
    int   mode  = 0;

    int checks = 0;
    int errors = 0;

    logic [2:0] xyz_a, xyz_b;
    logic [3:0] abcd_a, abcd_b, abcd_c;
    logic       busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
    logic [4:0] err_a, err_b, err_c;
    logic [3:0] ff_a, ff_b, ff_c;
    logic       fv_a, fv_b, fv_c;

    logic [3:0] m_abcd, m_ff;
    logic [4:0] m_err;
    logic       m_busy, m_done, m_pass, m_fv;

    always #5 clock = ~clock;

    // net1 model; mode 1: xyz forced to 111 at abcd=6; mode 2: inverted at 3, 9, 12.
    function automatic logic [2:0] model(input int md, input logic [3:0] a);
        logic [2:0] y;
        y = a[2:0];
        if (md == 1 && a == 4'd6) y = 3'b111;
        if (md == 2 && (a == 4'd3 || a == 4'd9 || a == 4'd12)) y = ~a[2:0];
        return y;
    endfunction

    assign xyz_a = model(mode, abcd_a);
    assign xyz_b = model(mode, abcd_b);

    net1_sweep_checker #(.HOLD_CYCLES(10), .EXPECTED(EXP_GOOD)) dut_a (
        .clock(clock), .reset(reset), .start(start && sel == 0), .xyz(xyz_a),
        .abcd(abcd_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail(ff_a), .fail_valid(fv_a)
    );

    net1_sweep_checker #(.HOLD_CYCLES(1), .EXPECTED(EXP_GOOD)) dut_b (
        .clock(clock), .reset(reset), .start(start && sel == 1), .xyz(xyz_b),
        .abcd(abcd_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail(ff_b), .fail_valid(fv_b)
    );

    net1_sweep_checker #(.HOLD_CYCLES(1), .EXPECTED(48'hFFFF_FFFF_FFFF)) dut_c (
        .clock(clock), .reset(reset), .start(start && sel == 2), .xyz(3'b000),
        .abcd(abcd_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_fail(ff_c), .fail_valid(fv_c)
    );

    always_comb begin
        m_abcd = abcd_a; m_busy = busy_a; m_done = done_a; m_pass = pass_a;
        m_err  = err_a;  m_ff   = ff_a;   m_fv   = fv_a;
        if (sel == 1) begin
            m_abcd = abcd_b; m_busy = busy_b; m_done = done_b; m_pass = pass_b;
            m_err  = err_b;  m_ff   = ff_b;   m_fv   = fv_b;
        end else if (sel == 2) begin
            m_abcd = abcd_c; m_busy = busy_c; m_done = done_c; m_pass = pass_c;
            m_err  = err_c;  m_ff   = ff_c;   m_fv   = fv_c;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse start, follow abcd/busy each cycle, optionally pulse start again at
    // cycle 'mid' (must be ignored), and measure cycles from start edge to done.
    task automatic run_sweep(input int h, input int mid);
        bit ok;
        int n;
        ok = 1'b1;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0; n = 0;
        check("start_clr", int'({m_done, m_pass, m_err, m_fv}), 0);
        while (!m_done && n < 20 * h + 20) begin
            start = (n == mid);
            if (m_abcd != 4'(n / h) || !m_busy) ok = 1'b0;
            @(negedge clock); n++;
        end
        start = 1'b0;
        check("abcd_step", int'(ok), 1);
        check("done_latency", n, 16 * h);
    endtask

    typedef struct {
        int sel;
        int h;
        int mode;
        int err;
        int first;
        int fv;
        int pass;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{0, 10, 0,  0, 0, 0, 1};
        vecs[1] = '{0, 10, 1,  1, 6, 1, 0};
        vecs[2] = '{0, 10, 2,  3, 3, 1, 0};
        vecs[3] = '{2,  1, 0, 16, 0, 1, 0};
        vecs[4] = '{1,  1, 2,  3, 3, 1, 0};

        #1;
        check("reset_a", int'({abcd_a, busy_a, done_a, pass_a, err_a, ff_a, fv_a}), 0);
        check("reset_b", int'({abcd_b, busy_b, done_b, pass_b, err_b, ff_b, fv_b}), 0);
        @(negedge clock); reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            sel  = vecs[i].sel;
            mode = vecs[i].mode;
            run_sweep(vecs[i].h, -1);
            check("err_count",  int'(m_err),  vecs[i].err);
            check("first_fail", int'(m_ff),   vecs[i].first);
            check("fail_valid", int'(m_fv),   vecs[i].fv);
            check("pass",       int'(m_pass), vecs[i].pass);
            check("busy_end",   int'(m_busy), 0);
            check("abcd_end",   int'(m_abcd), 15);
        end

        // Extra start mid-sweep on B is ignored; single fault still scored.
        sel = 1; mode = 1;
        run_sweep(1, 5);
        check("mid_start_err", int'(m_err), 1);
        check("mid_start_ff",  int'(m_ff),  6);
        check("mid_start_pass", int'(m_pass), 0);

        // Restart from DONE: done/pass/err clear on the start edge, clean rerun.
        mode = 0;
        run_sweep(1, -1);
        check("rerun_err",  int'(m_err),  0);
        check("rerun_pass", int'(m_pass), 1);
        check("rerun_done", int'(m_done), 1);

        // Asynchronous reset 37 cycles into an A sweep.
        sel = 0; mode = 0;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (37) @(negedge clock);
        check("pre_reset_abcd", int'(abcd_a), 3);
        check("pre_reset_busy", int'(busy_a), 1);
        #2 reset = 1'b1;
        #1 check("async_reset", int'({abcd_a, busy_a, done_a, pass_a, err_a, ff_a, fv_a}), 0);
        @(negedge clock); reset = 1'b0;
        @(negedge clock);
        check("idle_after_reset", int'({abcd_a, busy_a, done_a}), 0);
        run_sweep(10, -1);
        check("post_reset_pass", int'(pass_a), 1);
        check("post_reset_err",  int'(err_a),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
